// File: rtl/idma_sram_pkg.sv
//==============================================================================
// Module  : idma_sram_pkg
// Purpose : Shared geometry and request record for the iDMA SRAM arbiter.
//           Defines the macro word-address width, data width, strobe width and
//           the per-access request bundle that is steered onto the macro pins.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package idma_sram_pkg;

  localparam int AW     = 10;
  localparam int DW     = 128;
  localparam int STRB_W = DW / 8;

  typedef struct packed {
    logic              wen;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic [STRB_W-1:0] wstrb;
  } sram_req_t;

endpackage

`default_nettype wire

// File: rtl/idma_sram_rsp_fifo.sv
//==============================================================================
// Module  : idma_sram_rsp_fifo
// Purpose : Ordered circular FIFO that holds read responses until the consumer
//           takes them. Push and pop may coincide, also when full or empty.
//           There is no bypass: a word pushed into an empty FIFO is visible on
//           o_rdata one cycle later.
// Ports   : clk, rst      - clock, synchronous active-high reset (flushes)
//           i_push/i_wdata - enqueue one word
//           i_pop          - dequeue the head word (ignored when empty)
//           o_rdata        - head word
//           o_full/o_empty - occupancy flags
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module idma_sram_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  import idma_sram_pkg::*;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointer increment with wrap, so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/idma_sram_arb.sv
//==============================================================================
// Module  : idma_sram_arb
// Purpose : Round-robin arbiter/sequencer sharing one single-port 1024x128b
//           SRAM among NUM_REQ iDMA masters. Only driver of the macro pins.
// Ports   : clk, rst                   - clock, synchronous active-high reset
//           req_valid/ready/wen/addr/
//           wdata/wstrb                 - per-master command ports (packed)
//           rsp_valid/ready/id/rdata    - shared, in-order read response port
//           sram_cen/wen/addr/wdata/
//           wstrb, sram_rdata           - macro pins (rdata one cycle late)
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module idma_sram_arb #(
  parameter  int NUM_REQ   = 2,
  parameter  int AW        = idma_sram_pkg::AW,
  parameter  int DW        = idma_sram_pkg::DW,
  parameter  int RSP_DEPTH = 2,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_wen,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*DW-1:0]   req_wdata,
  input  logic [NUM_REQ*DW/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [DW-1:0]           rsp_rdata,
  output logic                    sram_cen,
  output logic                    sram_wen,
  output logic [AW-1:0]           sram_addr,
  output logic [DW-1:0]           sram_wdata,
  output logic [DW/8-1:0]         sram_wstrb,
  input  logic [DW-1:0]           sram_rdata
);
  import idma_sram_pkg::*;

  localparam int SW  = DW / 8;
  localparam int CRW = $clog2(RSP_DEPTH + 1);

  if (NUM_REQ < 1 || NUM_REQ > 4) begin : g_bad_num_req
    $error("idma_sram_arb: NUM_REQ=%0d outside 1..4", NUM_REQ);
  end
  if (RSP_DEPTH < 1) begin : g_bad_depth
    $error("idma_sram_arb: RSP_DEPTH=%0d must be at least 1", RSP_DEPTH);
  end
  // The steering record is sized by the package geometry.
  if (AW != idma_sram_pkg::AW || DW != idma_sram_pkg::DW) begin : g_bad_geometry
    $error("idma_sram_arb: AW/DW must match idma_sram_pkg");
  end

  logic [IDW-1:0]     r_ptr;
  logic [CRW-1:0]     r_credits;
  logic               r_inflight;
  logic [IDW-1:0]     r_inflight_id;

  logic [NUM_REQ-1:0] w_eligible;
  logic               w_found;
  logic [IDW-1:0]     w_found_id;
  logic               w_gnt_vld;
  sram_req_t          w_sel;
  logic               w_rd_issue;
  logic               w_pop;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [IDW+DW-1:0]  w_fifo_rdata;

  // Reads are only eligible while a FIFO slot is reserved for their data.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_eligible[i] = req_valid[i] & (req_wen[i] | (r_credits != '0));
    end
  end

  // First eligible requester scanning from r_ptr in round-robin order.
  always_comb begin
    w_found    = 1'b0;
    w_found_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int             idx;
      logic [IDW-1:0] cand;
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDW'(idx);
      if (!w_found && w_eligible[cand]) begin
        w_found    = 1'b1;
        w_found_id = cand;
      end
    end
  end

  // Gating with rst drops the macro enable in the very cycle reset is sampled.
  assign w_gnt_vld = w_found & ~rst;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_gnt_vld && (w_found_id == IDW'(i));
      if (req_ready[i]) begin
        w_sel.wen   = req_wen[i];
        w_sel.addr  = req_addr[i*AW +: AW];
        w_sel.wdata = req_wdata[i*DW +: DW];
        w_sel.wstrb = req_wstrb[i*SW +: SW];
      end
    end
  end

  assign sram_cen   = w_gnt_vld;
  assign sram_wen   = w_sel.wen;
  assign sram_addr  = w_sel.addr;
  assign sram_wdata = w_sel.wdata;
  assign sram_wstrb = w_sel.wstrb;

  assign w_rd_issue = w_gnt_vld & ~w_sel.wen;
  assign rsp_valid  = ~w_fifo_empty & ~rst;
  assign w_pop      = rsp_valid & rsp_ready;
  assign rsp_id     = w_fifo_rdata[DW +: IDW];
  assign rsp_rdata  = w_fifo_rdata[DW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr         <= '0;
      r_credits     <= CRW'(RSP_DEPTH);
      r_inflight    <= 1'b0;
      r_inflight_id <= '0;
    end else begin
      if (w_gnt_vld) begin
        r_ptr <= (w_found_id == IDW'(NUM_REQ - 1)) ? '0 : w_found_id + IDW'(1);
      end
      if (w_rd_issue && !w_pop) begin
        r_credits <= r_credits - CRW'(1);
      end else if (!w_rd_issue && w_pop) begin
        r_credits <= r_credits + CRW'(1);
      end
      r_inflight    <= w_rd_issue;
      r_inflight_id <= w_found_id;
    end
  end

  // The macro returns data the cycle after the access; capture it with its ID.
  idma_sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (IDW + DW)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_wdata ({r_inflight_id, sram_rdata}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Credit accounting must make a push into a full, non-draining FIFO impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
                                   !(w_fifo_full && r_inflight && !w_pop));

endmodule

`default_nettype wire

// File: tb/tb_idma_sram_arb.sv
//==============================================================================
// Module  : tb_idma_sram_arb
// Purpose : Self-checking bench for idma_sram_arb with a behavioural SRAM
//           macro and a transaction-level reference model for random traffic.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_idma_sram_arb;

  localparam int NUM_REQ   = 2;
  localparam int AW        = 10;
  localparam int DW        = 128;
  localparam int SW        = DW / 8;
  localparam int RSP_DEPTH = 2;
  localparam int IDW       = 1;
  localparam int RND_LEN   = 400;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid, req_ready, req_wen;
  logic [NUM_REQ*AW-1:0]   req_addr;
  logic [NUM_REQ*DW-1:0]   req_wdata;
  logic [NUM_REQ*SW-1:0]   req_wstrb;
  logic                    rsp_valid, rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [DW-1:0]           rsp_rdata;
  logic                    sram_cen, sram_wen;
  logic [AW-1:0]           sram_addr;
  logic [DW-1:0]           sram_wdata;
  logic [SW-1:0]           sram_wstrb;
  logic [DW-1:0]           sram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  idma_sram_arb #(
    .NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_rdata(rsp_rdata),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb), .sram_rdata(sram_rdata)
  );

  // Unstrobed bytes are stored as zero.
  function automatic logic [DW-1:0] strobe_fill(input logic [DW-1:0] d, input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = '0;
    for (int b = 0; b < SW; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Behavioural SRAM macro.
  logic [DW-1:0] sram_mem [0:1023];
  always @(posedge clk) begin
    if (sram_cen) begin
      if (sram_wen) sram_mem[sram_addr] <= strobe_fill(sram_wdata, sram_wstrb);
      else          sram_rdata          <= sram_mem[sram_addr];
    end
  end

  // Reference model state (transaction level).
  typedef struct {
    int            id;
    logic [DW-1:0] data;
    bit            known;
    int            vis;
  } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem   [0:1023];
  bit            ref_known [0:1023];
  int            m_ptr;
  bit            mv [NUM_REQ];
  bit            mw [NUM_REQ];
  logic [AW-1:0] ma [NUM_REQ];
  logic [DW-1:0] md [NUM_REQ];
  logic [SW-1:0] ms [NUM_REQ];

  // Winner under the rules: RR from m_ptr, writes always, reads only with a free slot.
  function automatic int exp_grant();
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NUM_REQ;
      if (mv[idx] && (mw[idx] || exp_q.size() < RSP_DEPTH)) return idx;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_wen = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
  endtask

  task automatic set_req(input int i, input logic wen, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid[i] = 1'b1;
    req_wen[i]   = wen;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_wstrb[i*SW +: SW] = s;
  endtask

  task automatic drain(input int n);
    idle_inputs();
    rsp_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b0;
    idle_inputs();
    req_valid = '1;
    req_addr  = {10'h002, 10'h001};
    repeat (3) begin
      tick();
      n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
      n_checks++; if (sram_cen !== 1'b0) begin n_errors++; $display("FAIL reset_cen got %b want 0", sram_cen); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    end
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL reset_first_grant got %b want 01", req_ready); end
    n_checks++; if (sram_cen !== 1'b1) begin n_errors++; $display("FAIL reset_first_cen got %b want 1", sram_cen); end
    tick();
    drain(6);
  endtask

  task automatic test_write_read();
    logic [DW-1:0] pat;
    pat = {16{8'hA5}};
    set_req(0, 1'b1, 10'h3FF, pat, 16'hFFFF);
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL wr_ready got %b want 01", req_ready); end
    n_checks++; if ({sram_cen, sram_wen, sram_addr} !== {1'b1, 1'b1, 10'h3FF}) begin
      n_errors++; $display("FAIL wr_pins got cen=%b wen=%b addr=%h want 1 1 3ff", sram_cen, sram_wen, sram_addr); end
    n_checks++; if ({sram_wdata, sram_wstrb} !== {pat, 16'hFFFF}) begin
      n_errors++; $display("FAIL wr_data got %h/%h want %h/ffff", sram_wdata, sram_wstrb, pat); end
    tick();
    set_req(0, 1'b0, 10'h3FF, '0, '0);
    #1;
    n_checks++; if ({req_ready, sram_cen, sram_wen} !== {2'b01, 1'b1, 1'b0}) begin
      n_errors++; $display("FAIL rd_issue got ready=%b cen=%b wen=%b want 01 1 0", req_ready, sram_cen, sram_wen); end
    tick();
    idle_inputs(); rsp_ready = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rd_t1_valid got %b want 0", rsp_valid); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL rd_t2_valid got %b want 1", rsp_valid); end
    n_checks++; if (rsp_id !== 1'b0) begin n_errors++; $display("FAIL rd_t2_id got %0d want 0", rsp_id); end
    n_checks++; if (rsp_rdata !== pat) begin n_errors++; $display("FAIL rd_t2_data got %h want %h", rsp_rdata, pat); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rd_t3_valid got %b want 0", rsp_valid); end
  endtask

  task automatic test_rr_fairness();
    int n_gr, n_rs, gid;
    n_gr = 0; n_rs = 0;
    // A req1 write moves the pointer to req0.
    set_req(1, 1'b1, 10'h001, '0, 16'hFFFF);
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_errors++; $display("FAIL rr_setup got %b want 10", req_ready); end
    tick();
    idle_inputs(); rsp_ready = 1'b1;
    set_req(0, 1'b0, 10'h004, '0, '0);
    set_req(1, 1'b0, 10'h005, '0, '0);
    for (int c = 0; c < 22; c++) begin
      if (c == 16) idle_inputs();
      #1;
      if (req_ready != 2'b00) begin
        gid = req_ready[1] ? 1 : 0;
        n_checks++; if (gid != n_gr % 2) begin n_errors++; $display("FAIL rr_grant #%0d got %0d want %0d", n_gr, gid, n_gr % 2); end
        n_gr++;
      end
      if (rsp_valid) begin
        n_checks++; if (int'(rsp_id) != n_rs % 2) begin n_errors++; $display("FAIL rr_rsp_id #%0d got %0d want %0d", n_rs, rsp_id, n_rs % 2); end
        n_rs++;
      end
      tick();
    end
    n_checks++; if (n_gr < 4) begin n_errors++; $display("FAIL rr_grant_count got %0d want >=4", n_gr); end
    n_checks++; if (n_rs != n_gr) begin n_errors++; $display("FAIL rr_rsp_count got %0d want %0d", n_rs, n_gr); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d [3];
    int r0, w1, n_pop, first_pop, gnt3;
    for (int k = 0; k < 3; k++) begin
      d[k] = {4{32'hB0B0_0000 + 32'(k)}};
      set_req(0, 1'b1, AW'(10'h010 + k), d[k], 16'hFFFF);
      #1;
      n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL bp_prewrite%0d got %b want 01", k, req_ready); end
      tick();
    end
    idle_inputs(); rsp_ready = 1'b0;
    r0 = 0; w1 = 0;
    for (int c = 0; c < 12; c++) begin
      idle_inputs();
      if (r0 < 3) set_req(0, 1'b0, AW'(10'h010 + r0), '0, '0);
      if (w1 < 4) set_req(1, 1'b1, AW'(10'h020 + w1), {4{32'(w1)}}, 16'hFFFF);
      #1;
      if (req_ready[0]) r0++;
      if (req_ready[1]) w1++;
      tick();
    end
    n_checks++; if (r0 != 2) begin n_errors++; $display("FAIL bp_reads_accepted got %0d want 2", r0); end
    n_checks++; if (w1 != 4) begin n_errors++; $display("FAIL bp_writes_accepted got %0d want 4", w1); end
    idle_inputs();
    #1;
    n_checks++; if ({rsp_valid, rsp_id} !== {1'b1, 1'b0}) begin
      n_errors++; $display("FAIL bp_held got valid=%b id=%0d want 1 0", rsp_valid, rsp_id); end
    rsp_ready = 1'b1;
    n_pop = 0; first_pop = -1; gnt3 = -1;
    for (int c = 0; c < 12 && n_pop < 3; c++) begin
      idle_inputs();
      if (r0 < 3) set_req(0, 1'b0, AW'(10'h010 + r0), '0, '0);
      #1;
      if (rsp_valid) begin
        n_checks++; if ({rsp_id, rsp_rdata} !== {1'b0, d[n_pop]}) begin
          n_errors++; $display("FAIL bp_drain%0d got id=%0d %h want 0 %h", n_pop, rsp_id, rsp_rdata, d[n_pop]); end
        if (n_pop == 0) first_pop = c;
        n_pop++;
      end
      if (req_ready[0]) begin gnt3 = c; r0++; end
      tick();
    end
    n_checks++; if (n_pop != 3) begin n_errors++; $display("FAIL bp_drain_count got %0d want 3", n_pop); end
    n_checks++; if (!(gnt3 > first_pop && first_pop >= 0)) begin
      n_errors++; $display("FAIL bp_third_grant got cycle %0d want after pop cycle %0d", gnt3, first_pop); end
    drain(4);
  endtask

  task automatic test_partial_strobe();
    logic [DW-1:0] want;
    want = {64'h0, {64{1'b1}}};
    set_req(1, 1'b1, 10'h055, {DW{1'b1}}, 16'h00FF);
    #1;
    n_checks++; if ({req_ready, sram_wstrb, sram_wdata} !== {2'b10, 16'h00FF, {DW{1'b1}}}) begin
      n_errors++; $display("FAIL ps_write got ready=%b strb=%h data=%h", req_ready, sram_wstrb, sram_wdata); end
    tick();
    set_req(1, 1'b0, 10'h055, '0, '0);
    tick();
    idle_inputs(); rsp_ready = 1'b1;
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_rdata} !== {1'b1, 1'b1, want}) begin
      n_errors++; $display("FAIL ps_read got v=%b id=%0d %h want 1 1 %h", rsp_valid, rsp_id, rsp_rdata, want); end
    drain(3);
  endtask

  task automatic test_mid_reset();
    set_req(0, 1'b0, 10'h3FF, '0, '0);
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL mr_issue got %b want 01", req_ready); end
    tick();
    idle_inputs();
    rst = 1'b1;
    set_req(1, 1'b1, 10'h200, '1, '1);
    #1;
    n_checks++; if ({sram_cen, req_ready} !== 3'b000) begin
      n_errors++; $display("FAIL mr_cen_drop got cen=%b ready=%b want 0 00", sram_cen, req_ready); end
    tick();
    rst = 1'b0; idle_inputs();
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL mr_discard c%0d got %b want 0", c, rsp_valid); end
      tick();
    end
    rsp_ready = 1'b0;
    set_req(0, 1'b0, 10'h3FF, '0, '0);
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL mr_credit1 got %b want 01", req_ready); end
    tick();
    set_req(0, 1'b0, 10'h055, '0, '0);
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL mr_credit2 got %b want 01", req_ready); end
    tick();
    set_req(0, 1'b0, 10'h010, '0, '0);
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL mr_credit_limit got %b want 00", req_ready); end
    n_checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, {16{8'hA5}}}) begin
      n_errors++; $display("FAIL mr_rsp0 got v=%b %h", rsp_valid, rsp_rdata); end
    idle_inputs(); rsp_ready = 1'b1;
    tick();
    n_checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 64'h0, {64{1'b1}}}) begin
      n_errors++; $display("FAIL mr_rsp1 got v=%b %h", rsp_valid, rsp_rdata); end
    drain(4);
  endtask

  task automatic test_random();
    int            eg;
    bit            exp_v;
    logic [1:0]    exp_rdy;
    rst = 1'b1; idle_inputs(); rsp_ready = 1'b0;
    tick();
    rst = 1'b0;
    m_ptr = 0; exp_q.delete();
    for (int i = 0; i < 1024; i++) ref_known[i] = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) mv[i] = 1'b0;
    for (int cyc = 0; cyc < RND_LEN + 60; cyc++) begin
      if (cyc >= RND_LEN && exp_q.size() == 0 && !mv[0] && !mv[1]) break;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!mv[i] && cyc < RND_LEN && $urandom_range(0, 3) != 0) begin
          mv[i] = 1'b1;
          mw[i] = 1'($urandom_range(0, 1));
          ma[i] = AW'(10'h100 + $urandom_range(0, 7));
          md[i] = {$urandom, $urandom, $urandom, $urandom};
          ms[i] = ($urandom_range(0, 3) == 0) ? SW'($urandom) : '1;
        end
      end
      idle_inputs();
      for (int i = 0; i < NUM_REQ; i++) if (mv[i]) set_req(i, mw[i], ma[i], md[i], ms[i]);
      rsp_ready = (cyc >= RND_LEN) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      #1;
      eg      = exp_grant();
      exp_rdy = (eg < 0) ? 2'b00 : 2'(1 << eg);
      exp_v   = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
      n_checks++; if (req_ready !== exp_rdy) begin n_errors++; $display("FAIL rnd_ready c%0d got %b want %b", cyc, req_ready, exp_rdy); end
      n_checks++; if (sram_cen !== (eg >= 0)) begin n_errors++; $display("FAIL rnd_cen c%0d got %b want %b", cyc, sram_cen, eg >= 0); end
      if (eg >= 0) begin
        n_checks++; if ({sram_wen, sram_addr} !== {mw[eg], ma[eg]}) begin
          n_errors++; $display("FAIL rnd_pins c%0d got wen=%b addr=%h want %b %h", cyc, sram_wen, sram_addr, mw[eg], ma[eg]); end
      end
      n_checks++; if (rsp_valid !== exp_v) begin n_errors++; $display("FAIL rnd_rsp_valid c%0d got %b want %b", cyc, rsp_valid, exp_v); end
      if (exp_v) begin
        n_checks++; if (int'(rsp_id) != exp_q[0].id) begin
          n_errors++; $display("FAIL rnd_rsp_id c%0d got %0d want %0d", cyc, rsp_id, exp_q[0].id); end
        if (exp_q[0].known) begin
          n_checks++; if (rsp_rdata !== exp_q[0].data) begin
            n_errors++; $display("FAIL rnd_rdata c%0d got %h want %h", cyc, rsp_rdata, exp_q[0].data); end
        end
        if (rsp_ready) void'(exp_q.pop_front());
      end
      if (eg >= 0) begin
        m_ptr = (eg + 1) % NUM_REQ;
        if (mw[eg]) begin
          ref_mem[ma[eg]]   = strobe_fill(md[eg], ms[eg]);
          ref_known[ma[eg]] = 1'b1;
        end else begin
          exp_q.push_back('{id: eg, data: ref_mem[ma[eg]], known: ref_known[ma[eg]], vis: cyc + 2});
        end
        mv[eg] = 1'b0;
      end
      tick();
    end
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL rnd_leftover got %0d want 0", exp_q.size()); end
    drain(2);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_rr_fairness();
    test_backpressure();
    test_partial_strobe();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
